mux_scan_serializer: RTL and testbench

- Upstream sequencer for the 16:1 select mux: accepts a 16-bit word over a valid/ready handshake and walks the 4-bit select from 0 to 15, one step per bit period.
- Emits the selected bit serially with a valid and a per-bit strobe.
- The `sel` output drives an external 16:1 mux directly.
- The registered `ser_out` is produced internally from the same select, so downstream logic gets a clean, registered serial stream.

---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/scan_sel_counter.sv | 53 +++++
 rtl/mux_scan_serializer.sv | 135 +++++++++++++
 tb/tb_mux_scan_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants, state encoding and parity helper for the mux scan serializer.
// Optional parity stage is enabled by defining MUX_SCAN_SERIALIZER_PARITY_EN.
package mux_scan_pkg;

    localparam int unsigned WIDTH_C = 16;
    localparam int unsigned SEL_W_C = 4;

    localparam logic [SEL_W_C-1:0] SEL_MAX_C = SEL_W_C'(WIDTH_C - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } scan_state_t;

    // Even parity bit of a data word (XOR of all bits).
    function automatic logic even_parity(input logic [WIDTH_C-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/scan_sel_counter.sv
// Bit-period divider plus select counter for the mux scan serializer.
// clear forces count/sel to zero; enable advances the divider, stepping sel on wrap.
module scan_sel_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    output logic [SEL_W_C-1:0] sel,
    output logic               bit_stb,
    output logic               wrap_c,
    output logic               last_c
);

    localparam int unsigned    CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;

    assign wrap_c = (count_q == CNT_MAX);
    assign last_c = wrap_c && (sel == SEL_MAX_C);

    // Divider, select and strobe registers; strobe marks the first cycle of each bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sel     <= '0;
            bit_stb <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            sel     <= '0;
            bit_stb <= 1'b0;
        end else if (enable) begin
            if (wrap_c) begin
                count_q <= '0;
                bit_stb <= 1'b1;
                if (sel != SEL_MAX_C) begin
                    sel <= sel + SEL_W_C'(1);
                end
            end else begin
                count_q <= count_q + CNT_W'(1);
                bit_stb <= 1'b0;
            end
        end else begin
            // Frame start: counters already zero, first bit period begins next cycle.
            bit_stb <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Walks a 16:1 mux select across a captured word, LSB first, one step per bit period,
// and emits the selected bit as a registered serial stream.
// Define MUX_SCAN_SERIALIZER_PARITY_EN to append an even-parity bit period.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [WIDTH_C-1:0] load_data,
    output logic [SEL_W_C-1:0] sel,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               bit_stb,
    output logic               busy,
    output logic               done
);

    scan_state_t        state_q;
    scan_state_t        state_d;
    logic [WIDTH_C-1:0] word_q;
    logic               transfer_c;
    logic               ser_out_d;
    logic               ser_valid_d;
    logic               busy_d;
    logic               done_d;
    logic               load_ready_d;
    logic               cnt_clear_c;
    logic               cnt_enable_c;
    logic               wrap_c;
    logic               last_c;
    logic [SEL_W_C-1:0] sel_nx_c;

    assign cnt_clear_c  = (state_d == IDLE);
    assign cnt_enable_c = (state_q != IDLE);
    assign sel_nx_c     = sel + SEL_W_C'(1);

    scan_sel_counter #(
        .DIV (DIV)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear_c),
        .enable  (cnt_enable_c),
        .sel     (sel),
        .bit_stb (bit_stb),
        .wrap_c  (wrap_c),
        .last_c  (last_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        transfer_c   = 1'b0;
        ser_out_d    = ser_out;

        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    transfer_c = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (last_c) begin
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
            PAR: begin
                if (last_c) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Serial bit tracks the select the counter will present next cycle.
        if (state_d == IDLE) begin
            ser_out_d = 1'b0;
        end else if (transfer_c) begin
            ser_out_d = load_data[0];
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
        end else if (state_d == PAR) begin
            ser_out_d = even_parity(word_q);
`endif
        end else if (wrap_c) begin
            ser_out_d = word_q[sel_nx_c];
        end

        ser_valid_d  = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_q != IDLE) && (state_d == IDLE);
        load_ready_d = (state_d == IDLE);
    end

    // Word capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            if (transfer_c) begin
                word_q <= load_data;
            end
            ser_out    <= ser_out_d;
            ser_valid  <= ser_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            load_ready <= load_ready_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: DIV=1 and DIV=3 instances share one clock.
module tb_mux_scan_serializer;

    typedef struct {
        logic [15:0] word;
        logic        par;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DIV = 1 instance
    logic        rst1_n;
    logic        lv1;
    logic [15:0] ld1;
    logic        lr1;
    logic [3:0]  sel1;
    logic        so1, sv1, stb1, busy1, done1;

    // DIV = 3 instance
    logic        rst3_n;
    logic        lv3;
    logic [15:0] ld3;
    logic        lr3;
    logic [3:0]  sel3;
    logic        so3, sv3, stb3, busy3, done3;

    int n_checks = 0;
    int n_fail   = 0;

    mux_scan_serializer #(.DIV(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .load_valid (lv1),
        .load_ready (lr1),
        .load_data  (ld1),
        .sel        (sel1),
        .ser_out    (so1),
        .ser_valid  (sv1),
        .bit_stb    (stb1),
        .busy       (busy1),
        .done       (done1)
    );

    mux_scan_serializer #(.DIV(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst3_n),
        .load_valid (lv3),
        .load_ready (lr3),
        .load_data  (ld3),
        .sel        (sel3),
        .ser_out    (so3),
        .ser_valid  (sv3),
        .bit_stb    (stb3),
        .busy       (busy3),
        .done       (done3)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks a DIV=1 frame starting in its first bit cycle; returns in the done cycle.
    task automatic expect_frame1(input logic [15:0] w, input logic p);
        for (int k = 0; k < 16; k++) begin
            check("sel",        k, 32'(sel1),  32'(k));
            check("ser_out",    k, 32'(so1),   32'(w[k]));
            check("ser_valid",  k, 32'(sv1),   32'd1);
            check("bit_stb",    k, 32'(stb1),  32'd1);
            check("busy",       k, 32'(busy1), 32'd1);
            check("done_early", k, 32'(done1), 32'd0);
            check("load_ready", k, 32'(lr1),   32'd0);
            tick();
        end
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
        check("par_sel",   0, 32'(sel1), 32'd15);
        check("par_bit",   0, 32'(so1),  32'(p));
        check("par_valid", 0, 32'(sv1),  32'd1);
        check("par_stb",   0, 32'(stb1), 32'd1);
        check("par_done",  0, 32'(done1), 32'd0);
        tick();
`else
        check("word_parity_ref", 0, 32'(^w), 32'(p));
`endif
        check("done",            0, 32'(done1), 32'd1);
        check("done_load_ready", 0, 32'(lr1),   32'd1);
        check("done_ser_valid",  0, 32'(sv1),   32'd0);
        check("done_busy",       0, 32'(busy1), 32'd0);
        check("done_sel",        0, 32'(sel1),  32'd0);
    endtask

    task automatic start1(input logic [15:0] w);
        lv1 = 1'b1;
        ld1 = w;
        tick();
        lv1 = 1'b0;
        ld1 = ~w;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'h3F0A, 1'b0};
        vecs[1] = '{16'h8001, 1'b0};
        vecs[2] = '{16'h0001, 1'b1};
        vecs[3] = '{16'hFFFF, 1'b0};
        vecs[4] = '{16'h1234, 1'b1};
        vecs[5] = '{16'hAAAA, 1'b0};

        rst1_n = 1'b0; rst3_n = 1'b0;
        lv1 = 1'b0; ld1 = '0;
        lv3 = 1'b0; ld3 = '0;
        #3;
        check("rst_sel",       0, 32'(sel1),  32'd0);
        check("rst_ser_out",   0, 32'(so1),   32'd0);
        check("rst_ser_valid", 0, 32'(sv1),   32'd0);
        check("rst_bit_stb",   0, 32'(stb1),  32'd0);
        check("rst_busy",      0, 32'(busy1), 32'd0);
        check("rst_done",      0, 32'(done1), 32'd0);
        tick();
        tick();
        rst1_n = 1'b1; rst3_n = 1'b1;
        check("rel_load_ready", 0, 32'(lr1), 32'd1);

        // Idle hold
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_ser_valid",  c, 32'(sv1),   32'd0);
            check("idle_busy",       c, 32'(busy1), 32'd0);
            check("idle_done",       c, 32'(done1), 32'd0);
            check("idle_sel",        c, 32'(sel1),  32'd0);
            check("idle_load_ready", c, 32'(lr1),   32'd1);
        end

        // Table-driven DIV=1 frames
        foreach (vecs[i]) begin
            start1(vecs[i].word);
            expect_frame1(vecs[i].word, vecs[i].par);
            tick();
            check("done_pulse_len", i, 32'(done1), 32'd0);
            tick();
        end

        // Handshake: valid held through the frame, second word taken in the done cycle
        lv1 = 1'b1;
        ld1 = 16'hAAAA;
        tick();
        ld1 = 16'h5555;
        expect_frame1(16'hAAAA, 1'b0);
        tick();
        lv1 = 1'b0;
        ld1 = 16'h0000;
        expect_frame1(16'h5555, 1'b0);
        tick();
        check("b2b_done_len", 0, 32'(done1), 32'd0);

        // Mid-frame asynchronous reset at sel = 7
        start1(16'h3F0A);
        for (int k = 0; k < 7; k++) tick();
        check("pre_rst_sel", 0, 32'(sel1), 32'd7);
        #2;
        rst1_n = 1'b0;
        #1;
        check("mrst_sel",       0, 32'(sel1),  32'd0);
        check("mrst_ser_out",   0, 32'(so1),   32'd0);
        check("mrst_ser_valid", 0, 32'(sv1),   32'd0);
        check("mrst_bit_stb",   0, 32'(stb1),  32'd0);
        check("mrst_busy",      0, 32'(busy1), 32'd0);
        check("mrst_done",      0, 32'(done1), 32'd0);
        tick();
        rst1_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_done",       c, 32'(done1), 32'd0);
            check("post_rst_load_ready", c, 32'(lr1),   32'd1);
        end
        start1(16'hFFFF);
        expect_frame1(16'hFFFF, 1'b0);
        tick();

        // DIV=3 frame with 16'h8001
        lv3 = 1'b1;
        ld3 = 16'h8001;
        tick();
        lv3 = 1'b0;
        ld3 = 16'h7FFE;
        for (int c = 1; c <= 48; c++) begin
            check("d3_sel",       c, 32'(sel3), 32'((c - 1) / 3));
            check("d3_bit_stb",   c, 32'(stb3), 32'(((c - 1) % 3) == 0));
            check("d3_ser_out",   c, 32'(so3),  32'((c <= 3) || (c >= 46)));
            check("d3_ser_valid", c, 32'(sv3),  32'd1);
            check("d3_done",      c, 32'(done3), 32'd0);
            tick();
        end
`ifdef MUX_SCAN_SERIALIZER_PARITY_EN
        for (int c = 0; c < 3; c++) begin
            check("d3_par_sel", c, 32'(sel3), 32'd15);
            check("d3_par_stb", c, 32'(stb3), 32'(c == 0));
            check("d3_par_bit", c, 32'(so3),  32'd0);
            check("d3_par_val", c, 32'(sv3),  32'd1);
            tick();
        end
`endif
        check("d3_done_cycle", 0, 32'(done3), 32'd1);
        check("d3_done_valid", 0, 32'(sv3),   32'd0);
        check("d3_done_ready", 0, 32'(lr3),   32'd1);
        tick();
        check("d3_done_len",   0, 32'(done3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
